// File: rtl/time_stamper_pkg.sv
// ----------------------------------------------------------------------------
// time_stamper_pkg
//   Shared parking definitions: default slot count and time-stamp width, the
//   exit FSM state encoding, the per-cycle request decision record and a
//   helper for the slot-index width.
// ----------------------------------------------------------------------------
package time_stamper_pkg;

    // Defaults for the parking lot size and the time-stamp width. The width
    // matches the 8-bit operands of the downstream duration subtractor.
    localparam int unsigned NumSlots   = 8;
    localparam int unsigned StampWidth = 8;

    // Exit FSM encoding, kept as plain constants for older consumers.
    localparam int unsigned StateWidth = 1;
    localparam logic [StateWidth-1:0] StIdle    = 1'b0;
    localparam logic [StateWidth-1:0] StPresent = 1'b1;

    // Outcome of one cycle's entry/exit requests, judged on pre-edge occupancy.
    typedef struct packed {
        logic entry_ok;  // entry accepted, slot gets stamped and marked occupied
        logic exit_ok;   // exit accepted, stamp pair loaded and slot freed
        logic reject;    // at least one request refused this cycle
    } req_decision_t;

    // Slot index width; a single-slot lot still needs a 1-bit index port.
    function automatic int unsigned slot_idx_width(input int unsigned slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/time_stamper_time_base.sv
// ----------------------------------------------------------------------------
// time_base_counter
//   TW-bit free-running time base. Advances by one on every cycle with tick
//   high and wraps from 2^TW-1 back to 0. Cleared by synchronous reset.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   tick   in   advance enable
//   count  out  current time (value before this cycle's increment)
// ----------------------------------------------------------------------------
module time_base_counter #(
    parameter int unsigned TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    output logic [TW-1:0] count
);

    localparam logic [TW-1:0] One = 1;

    logic [TW-1:0] count_q;

    // Wrap-around comes for free from the fixed-width add.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= count_q + One;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/time_stamper.sv
// ----------------------------------------------------------------------------
// time_stamper
//   Per-slot parking time stamper. An accepted entry records the current time
//   in the slot; an accepted exit presents the stored entry time together with
//   the current time as a stamp pair until the consumer acknowledges it. The
//   pair feeds a modulo-2^TW duration subtractor directly, so wrap-around of
//   the time base is deliberately left uncorrected here.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset (drops any pending stamp)
//   tick         in   time-base pulse, advances current time by one
//   car_in       in   entry request for in_slot
//   in_slot      in   entry slot index
//   car_out      in   exit request for out_slot
//   out_slot     in   exit slot index
//   stamp_ack    in   consumer has taken the presented stamp pair
//   time_in      out  stored entry time of the exiting car
//   time_out     out  current time captured at the accepted exit
//   stamp_valid  out  time_in/time_out pair valid (PRESENT state)
//   exit_ready   out  an exit can be accepted this cycle (IDLE state)
//   occupied     out  per-slot occupancy flags
//   err          out  one-cycle pulse after any rejected request
// ----------------------------------------------------------------------------
module time_stamper
    import time_stamper_pkg::*;
#(
    parameter int unsigned SLOTS = NumSlots,
    parameter int unsigned TW    = StampWidth,
    localparam int unsigned SW   = slot_idx_width(SLOTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             car_in,
    input  logic [SW-1:0]    in_slot,
    input  logic             car_out,
    input  logic [SW-1:0]    out_slot,
    input  logic             stamp_ack,
    output logic [TW-1:0]    time_in,
    output logic [TW-1:0]    time_out,
    output logic             stamp_valid,
    output logic             exit_ready,
    output logic [SLOTS-1:0] occupied,
    output logic             err
);

    // ------------------------------------------------------------------------
    // Time base
    // ------------------------------------------------------------------------
    logic [TW-1:0] now;

    time_base_counter #(
        .TW (TW)
    ) u_time_base (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .count (now)
    );

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [StateWidth-1:0] state_q, state_d;
    logic [SLOTS-1:0]      occ_q, occ_d;
    logic [TW-1:0]         time_in_q, time_out_q;
    logic                  err_q;
    logic [TW-1:0]         slot_time_q [SLOTS];

    req_decision_t dec;

    // ------------------------------------------------------------------------
    // Request decision
    // ------------------------------------------------------------------------
    // Both requests look only at occ_q, so a same-slot pair resolves as:
    // occupied slot -> exit wins, entry refused; free slot -> entry wins,
    // exit refused. Different slots never interact.
    always_comb begin
        dec          = '0;
        dec.entry_ok = car_in && !occ_q[in_slot];
        dec.exit_ok  = car_out && occ_q[out_slot] && (state_q == StIdle);
        // A single flag, so two refusals in one cycle still give one pulse.
        dec.reject   = (car_in && !dec.entry_ok) || (car_out && !dec.exit_ok);
    end

    always_comb begin
        occ_d = occ_q;
        if (dec.exit_ok) begin
            occ_d[out_slot] = 1'b0;
        end
        // An accepted entry and an accepted exit always target different slots.
        if (dec.entry_ok) begin
            occ_d[in_slot] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Exit FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (dec.exit_ok) begin
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (stamp_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            occ_q      <= '0;
            time_in_q  <= '0;
            time_out_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            err_q   <= dec.reject;
            // Only loaded on an accepted exit, which requires IDLE, so the
            // pair stays frozen for the whole PRESENT interval.
            if (dec.exit_ok) begin
                time_in_q  <= slot_time_q[out_slot];
                time_out_q <= now;
            end
        end
    end

    // Slot time storage has no reset: occupied gates every read of it.
    always_ff @(posedge clk) begin
        if (!rst && dec.entry_ok) begin
            slot_time_q[in_slot] <= now;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign time_in     = time_in_q;
    assign time_out    = time_out_q;
    assign stamp_valid = (state_q == StPresent);
    assign exit_ready  = (state_q == StIdle);
    assign occupied    = occ_q;
    assign err         = err_q;

endmodule

// File: doc/time_stamper.md
TIME_STAMPER -- requirements
Module: time_stamper

Interface
REQ-001 SHALL have parameter SLOTS, default 8, meaning the number of parking slots tracked.
REQ-002 SHALL have parameter TW, default 8, meaning the time-stamp width, matching the 8-bit time_in/time_out of the duration subtractor.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port tick  input  1  time-base pulse; advances the current time by one.
REQ-006 SHALL have port car_in  input  1  entry request for in_slot.
REQ-007 SHALL have port in_slot  input  log2(SLOTS)  entry slot index.
REQ-008 SHALL have port car_out  input  1  exit request for out_slot.
REQ-009 SHALL have port out_slot  input  log2(SLOTS)  exit slot index.
REQ-010 SHALL have port stamp_ack  input  1  consumer has taken the presented stamp pair.
REQ-011 SHALL have port time_in  output  TW  stored entry time of the exiting car.
REQ-012 SHALL have port time_out  output  TW  current time captured at the accepted exit.
REQ-013 SHALL have port stamp_valid  output  1  time_in/time_out pair valid.
REQ-014 SHALL have port exit_ready  output  1  an exit can be accepted this cycle.
REQ-015 SHALL have port occupied  output  SLOTS  per-slot occupancy flags.
REQ-016 SHALL have port err  output  1  one-cycle pulse on any rejected request.

Function
REQ-017 SHALL keep a TW-bit current-time counter that increments on each cycle with tick=1 and wraps from 2^TW-1 to 0.
REQ-018 SHALL, on car_in=1 with the slot free, store the pre-increment current time in that slot and set occupied[in_slot] at the next edge.
REQ-019 SHALL, on car_in=1 with the slot occupied, leave the slot unchanged and pulse err.
REQ-020 SHALL implement a two-state FSM: IDLE (exit_ready=1, stamp_valid=0) and PRESENT (exit_ready=0, stamp_valid=1).
REQ-021 SHALL, in IDLE with car_out=1 and the slot occupied, load time_in from the slot and load time_out with the pre-increment current time, clear occupied[out_slot], and enter PRESENT at the next edge (latency 1 cycle).
REQ-022 SHALL, on car_out=1 for an empty slot or while in PRESENT, ignore the request and pulse err.
REQ-023 SHALL hold time_in and time_out stable throughout PRESENT and return to IDLE on the edge where stamp_ack=1; stamp_ack in IDLE SHALL be ignored.
REQ-024 SHALL evaluate simultaneous entry and exit against pre-edge occupancy.
REQ-025 For simultaneous requests on different slots, both SHALL proceed.
REQ-026 For simultaneous requests on the same occupied slot, the exit SHALL be served and the entry rejected with err.
REQ-027 For simultaneous requests on the same free slot, the entry SHALL be accepted and the exit rejected with err.
REQ-028 SHALL pulse err only once per cycle when both requests are rejected in the same cycle.
REQ-029 SHALL not correct wrap-around: durations shorter than 2^TW ticks are resolved by the downstream modulo-2^TW subtraction.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, clear the time counter, occupied, time_in, time_out, stamp_valid and err, set exit_ready=1, and enter IDLE.
REQ-031 SHALL give reset priority over all requests, including a reset asserted in PRESENT, which drops the pending stamp.
REQ-032 Stored slot time values SHALL be don't-care after reset, since occupied gates their use.

Structure
REQ-033 SHALL take SLOTS, TW and the FSM state encoding from a shared parking package.
REQ-034 SHALL instantiate one sub-module, time_base_counter (TW-bit wrapping counter with tick enable and synchronous reset).
REQ-035 SHALL connect time_in and time_out directly to the existing duration subtractor without glue logic.

Verification
REQ-036 Bench SHALL apply: reset, 5 ticks, car_in slot 2, 7 ticks, car_out slot 2 -> next cycle stamp_valid=1, time_in=5, time_out=12, occupied[2]=0.
REQ-037 Bench SHALL apply: slot 3 entered at time 250, 10 ticks, exit -> time_in=250, time_out=4, so the subtractor yields 10.
REQ-038 Bench SHALL apply: car_in to occupied slot 1, then car_out from empty slot 4 -> err pulses 1 cycle each, no state change.
REQ-039 Bench SHALL apply: second car_out during PRESENT with stamp_ack held low 3 cycles -> err pulse, outputs stable, IDLE after ack.
REQ-040 Bench SHALL apply: simultaneous car_in and car_out on occupied slot 0 -> exit served, err=1, occupied[0]=0.
REQ-041 Bench SHALL apply: rst during PRESENT -> stamp_valid=0, occupied=0, time counter=0 on the next cycle.
